trig_compare: RTL and testbench

Parametrised hysteresis trigger comparator for the acquisition trigger path: compares a signed sample stream against a runtime threshold with a runtime hysteresis band, and debounces the result with a consecutive-sample filter. It outputs a filtered level plus a one-cycle trigger pulse on the selected edge, with optional holdoff. It sits between the ADC sample register and the trigger/capture controller.

---
 rtl/trig_compare_if.sv | 28 ++
 rtl/trig_compare.sv | 98 +++++++++
 tb/tb_trig_compare.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/trig_compare_if.sv
// Sample/threshold bundle between the ADC sample register and trig_compare,
// with the filtered level, trigger strobe and holdoff status returned.
interface trig_compare_if #(
  parameter int INPUT_WIDTH = 12,
  parameter int HYST_WIDTH  = 8,
  parameter int FILT_WIDTH  = 4,
  parameter int HOLD_WIDTH  = 16
);
  logic signed [INPUT_WIDTH-1:0] wave_in;
  logic signed [INPUT_WIDTH-1:0] trig_value;
  logic        [HYST_WIDTH-1:0]  hyst;
  logic        [FILT_WIDTH-1:0]  filt_len;
  logic        [1:0]             edge_sel;
  logic        [HOLD_WIDTH-1:0]  holdoff;
  logic                          level;
  logic                          trig_pulse;
  logic                          busy;

  modport master (
    output wave_in, trig_value, hyst, filt_len, edge_sel, holdoff,
    input  level, trig_pulse, busy
  );

  modport slave (
    input  wave_in, trig_value, hyst, filt_len, edge_sel, holdoff,
    output level, trig_pulse, busy
  );
endinterface

// File: rtl/trig_compare.sv
// Hysteresis trigger comparator with consecutive-sample filter and edge strobe; level/pulse
// update on the edge sampling the qualifying sample, no backpressure. TRIG_HOLDOFF_EN builds holdoff/busy.
module trig_compare #(
  parameter int INPUT_WIDTH = 12,
  parameter int HYST_WIDTH  = 8,
  parameter int FILT_WIDTH  = 4,
  parameter int HOLD_WIDTH  = 16
) (
  input  logic          clk_in,
  input  logic          RST,
  trig_compare_if.slave bus
);
  localparam int AW = INPUT_WIDTH + 2;

  logic signed [AW-1:0]     wave_x, trig_x, hyst_x, hi_th, lo_th;
  logic                     cand_hi, cand_lo, opposite, toggle;
  logic                     rise_ev, fall_ev, edge_match, pulse_d;
  logic [FILT_WIDTH-1:0]    filt_thr, filt_cnt;
  logic [FILT_WIDTH:0]      cnt_next;
  logic                     level_q, trig_pulse_q, busy_w;

  // Two guard bits keep trig_value +/- hyst exact for any input.
  assign wave_x = {{2{bus.wave_in[INPUT_WIDTH-1]}}, bus.wave_in};
  assign trig_x = {{2{bus.trig_value[INPUT_WIDTH-1]}}, bus.trig_value};
  assign hyst_x = {{(AW-HYST_WIDTH){1'b0}}, bus.hyst};
  assign hi_th  = trig_x + hyst_x;
  assign lo_th  = trig_x - hyst_x;

  assign cand_hi  = wave_x > hi_th;
  assign cand_lo  = wave_x < lo_th;
  assign opposite = level_q ? cand_lo : cand_hi;

  assign filt_thr = (bus.filt_len == '0) ? FILT_WIDTH'(1) : bus.filt_len;
  assign cnt_next = {1'b0, filt_cnt} + (FILT_WIDTH+1)'(1);
  assign toggle   = opposite && (cnt_next >= {1'b0, filt_thr});

  assign rise_ev = toggle && !level_q;
  assign fall_ev = toggle && level_q;

  always_comb begin
    edge_match = 1'b0;
    case (bus.edge_sel)
      2'b00:   edge_match = rise_ev;
      2'b01:   edge_match = fall_ev;
      2'b10:   edge_match = toggle;
      default: edge_match = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      level_q      <= 1'b0;
      filt_cnt     <= '0;
      trig_pulse_q <= 1'b0;
    end else begin
      trig_pulse_q <= pulse_d;
      if (toggle) begin
        level_q  <= ~level_q;
        filt_cnt <= '0;
      end else if (opposite) begin
        filt_cnt <= cnt_next[FILT_WIDTH-1:0];
      end else begin
        filt_cnt <= '0;
      end
    end
  end

`ifdef TRIG_HOLDOFF_EN
  logic [HOLD_WIDTH-1:0] hold_cnt;
  logic                  hold_ok;

  // Counter loads the cycle after the strobe so busy trails trig_pulse; the strobe cycle
  // itself is blocked unless holdoff is zero, giving a spacing of holdoff+1.
  assign hold_ok = (hold_cnt <= HOLD_WIDTH'(1)) && !(trig_pulse_q && (bus.holdoff != '0));
  assign pulse_d = edge_match && hold_ok;
  assign busy_w  = (hold_cnt != '0);

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      hold_cnt <= '0;
    end else if (trig_pulse_q) begin
      hold_cnt <= bus.holdoff;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HOLD_WIDTH'(1);
    end
  end
`else
  logic unused_holdoff;

  assign unused_holdoff = ^bus.holdoff;
  assign pulse_d        = edge_match;
  assign busy_w         = 1'b0;
`endif

  assign bus.level      = level_q;
  assign bus.trig_pulse = trig_pulse_q;
  assign bus.busy       = busy_w;
endmodule

// File: tb/tb_trig_compare.sv
// Randomized and directed bench for trig_compare against a cycle-indexed behavioural model.
module tb_trig_compare;
  localparam int IW = 12, HW = 8, FW = 4, DW = 16;

  logic clk_in = 1'b0;
  logic RST    = 1'b0;
  always #5 clk_in = ~clk_in;

  trig_compare_if #(.INPUT_WIDTH(IW), .HYST_WIDTH(HW), .FILT_WIDTH(FW), .HOLD_WIDTH(DW)) bus ();

  trig_compare #(.INPUT_WIDTH(IW), .HYST_WIDTH(HW), .FILT_WIDTH(FW), .HOLD_WIDTH(DW)) dut (
    .clk_in (clk_in),
    .RST    (RST),
    .bus    (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  string phase    = "init";

  // Model: level, run length of opposite samples, edge index of last strobe and its holdoff.
  int cyc     = 0;
  int m_level = 0;
  int m_run   = 0;
  int m_pulse = 0;
  int m_last  = -1000000;
  int m_hlen  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s/%s at cycle %0d: got %0d expected %0d", phase, tag, cyc, got, exp);
    end
  endtask

  function automatic int model_busy();
`ifdef TRIG_HOLDOFF_EN
    return ((cyc - m_last) >= 1 && (cyc - m_last) <= m_hlen) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic int model_idle();
`ifdef TRIG_HOLDOFF_EN
    return (m_hlen == 0 || (cyc - m_last) > m_hlen) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  task automatic model_step();
    int w, tv, h, fl, es, need;
    bit opp, rising, want;
    w  = int'(bus.wave_in);
    tv = int'(bus.trig_value);
    h  = int'(bus.hyst);
    fl = int'(bus.filt_len);
    es = int'(bus.edge_sel);
    cyc++;
    m_pulse = 0;
    opp = (m_level == 0) ? (w > tv + h) : (w < tv - h);
    if (!opp) begin
      m_run = 0;
    end else begin
      m_run++;
      need = (fl == 0) ? 1 : fl;
      if (m_run >= need) begin
        m_level = 1 - m_level;
        m_run   = 0;
        rising  = (m_level == 1);
        want    = (es == 2) || (es == 0 && rising) || (es == 1 && !rising);
        if (want && model_idle() == 1) begin
          m_pulse = 1;
          m_last  = cyc;
          m_hlen  = int'(bus.holdoff);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
    check("level", 32'(bus.level), 32'(m_level));
    check("pulse", 32'(bus.trig_pulse), 32'(m_pulse));
    check("busy", 32'(bus.busy), 32'(model_busy()));
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    m_level = 0; m_run = 0; m_pulse = 0; m_last = -1000000; m_hlen = 0;
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_pulse", 32'(bus.trig_pulse), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk_in);
    #1;
    RST = 1'b0;
  endtask

  task automatic set_wave(input int w);
    int c;
    c = (w > 2047) ? 2047 : ((w < -2048) ? -2048 : w);
    bus.wave_in = c[IW-1:0];
  endtask

  task automatic set_cfg(input int tv, input int h, input int fl, input int es, input int ho);
    bus.trig_value = tv[IW-1:0];
    bus.hyst       = h[HW-1:0];
    bus.filt_len   = fl[FW-1:0];
    bus.edge_sel   = es[1:0];
    bus.holdoff    = ho[DW-1:0];
  endtask

  task automatic square(input int half, input int n);
    for (int i = 0; i < n; i++) begin
      set_wave(((i / half) % 2 == 1) ? 200 : 0);
      tick();
    end
  endtask

  initial begin
    set_cfg(0, 0, 1, 0, 0);
    set_wave(0);
    #1 RST = 1'b1;
    #1;
    check("por_level", 32'(bus.level), 32'd0);
    check("por_pulse", 32'(bus.trig_pulse), 32'd0);
    check("por_busy", 32'(bus.busy), 32'd0);
    do_reset();

    phase = "basic";
    set_cfg(100, 20, 1, 0, 0);
    set_wave(0);   repeat (2) tick();
    set_wave(120); repeat (3) tick();
    set_wave(121); repeat (2) tick();

    phase = "hyst";
    for (int w = 121; w >= 80; w--) begin set_wave(w); tick(); end
    set_wave(79); repeat (2) tick();

    phase = "filter";
    set_cfg(100, 20, 4, 0, 0);
    set_wave(130); repeat (3) tick();
    set_wave(100); tick();
    set_wave(130); repeat (6) tick();
    set_wave(0);   repeat (6) tick();

    phase = "both_edges";
    set_cfg(100, 20, 1, 2, 0);
    square(2, 16);
    phase = "no_pulse";
    set_cfg(100, 20, 1, 3, 0);
    square(2, 16);
    set_wave(0); repeat (3) tick();

    phase = "holdoff_rise";
    set_cfg(100, 20, 1, 0, 10);
    square(2, 60);
    set_wave(0); repeat (14) tick();
    phase = "holdoff_both";
    set_cfg(100, 20, 1, 2, 10);
    square(2, 60);
    set_wave(0); repeat (14) tick();
    phase = "holdoff_zero";
    set_cfg(100, 20, 1, 2, 0);
    square(1, 12);
    set_wave(0); repeat (3) tick();

    phase = "rst_mid_holdoff";
    set_cfg(100, 20, 1, 0, 10);
    set_wave(200); repeat (4) tick();
    do_reset();
    set_wave(0); repeat (3) tick();

    phase = "extreme_hi";
    set_cfg(2047, 255, 1, 2, 0);
    for (int w = -2048; w <= 2047; w += 37) begin set_wave(w); tick(); end
    set_wave(2047); repeat (2) tick();
    phase = "extreme_lo";
    set_cfg(-2048, 255, 1, 2, 0);
    set_wave(2047); repeat (2) tick();
    for (int w = 2047; w >= -2048; w -= 41) begin set_wave(w); tick(); end
    set_wave(-2048); repeat (2) tick();

    phase = "random";
    for (int blk = 0; blk < 120; blk++) begin
      int tv, h, span;
      // Settle so the holdoff in force is never changed under a running count.
      for (int g = 0; g < 40 && (model_busy() == 1 || m_pulse == 1); g++) tick();
      tv = int'($urandom_range(0, 4095)) - 2048;
      h  = int'($urandom_range(0, 255));
      set_cfg(tv, h, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 6)));
      span = h + 8;
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(0, 9) == 0) set_wave(int'($urandom_range(0, 4095)) - 2048);
        else set_wave(tv + int'($urandom_range(0, 2 * span)) - span);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
